// File: rtl/isa_tx_seq_pkg.sv
// Shared types for the ISA tx sequencer: FSM states, word classes, trigger address.
// Optional statistics outputs are enabled with the ISA_TX_SEQ_STATS_EN macro.
package isa_tx_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_WAIT,
      ST_DONE
   } seq_state_e;

   typedef enum logic [1:0] {
      WC_TRIG,
      WC_ZERO,
      WC_TS
   } word_class_e;

   localparam logic [31:0] TRIG_ADDR_DEFAULT = 32'h0200_1000;

   function automatic word_class_e classify_word(input logic [63:0] word,
                                                 input logic [31:0] trig_addr);
      if (word[63:32] == trig_addr) begin
         return WC_TRIG;
      end else if (word == '0) begin
         return WC_ZERO;
      end else begin
         return WC_TS;
      end
   endfunction

endpackage

// File: rtl/isa_tx_seq_fifo.sv
// Show-ahead synchronous FIFO, DEPTH x 64; a push while full is accepted only
// when a pop frees the head entry in the same cycle.
module isa_tx_seq_fifo #(
   parameter int unsigned DEPTH = 16,
   localparam int unsigned AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [63:0]   wr_data,
   input  logic          rd_en,
   output logic [63:0]   rd_data,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   free_next
);

   logic [63:0]   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          push;
   logic          pop;

   assign full    = (count_q == (AW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign rd_data = mem_q[rd_ptr_q];

   always_comb begin
      pop       = rd_en && !empty;
      push      = wr_en && (!full || pop);
      wr_ptr_d  = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d  = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d   = count_q + (AW+1)'(push) - (AW+1)'(pop);
      free_next = (AW+1)'(DEPTH) - count_d;
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/isa_tx_sequencer.sv
// Replays buffered ISA tx words against a free-running timer: TRIG arms a run,
// ZERO rebases time, TS words fire O_play. Macro ISA_TX_SEQ_STATS_EN adds counters.
module isa_tx_sequencer
   import isa_tx_seq_pkg::*;
#(
   parameter int unsigned DEPTH        = 16,
   parameter int unsigned TS_W         = 48,
   parameter int unsigned READY_MARGIN = 2,
   parameter logic [31:0] TRIG_ADDR    = TRIG_ADDR_DEFAULT
) (
   input  logic             I_clk,
   input  logic             I_rst,
   input  logic [63:0]      I_tx_data,
   input  logic             I_tx_en,
   output logic             O_tx_ready,
   output logic             O_run,
   output logic             O_play,
   output logic [TS_W-1:0]  O_play_ts,
   output logic [31:0]      O_play_cnt,
   output logic [31:0]      O_trig_num,
   output logic             O_done,
   output logic             O_late,
   output logic             O_ovf
`ifdef ISA_TX_SEQ_STATS_EN
   ,output logic [15:0]     O_late_cnt,
   output logic [15:0]      O_drop_cnt
`endif
);

   localparam int unsigned AW = $clog2(DEPTH);

   seq_state_e       state_q, state_d;
   logic [TS_W-1:0]  timer_q, timer_d;
   logic [TS_W-1:0]  target_q, target_d;
   logic             run_q, run_d;
   logic             play_q, play_d;
   logic [TS_W-1:0]  play_ts_q, play_ts_d;
   logic [31:0]      play_cnt_q, play_cnt_d;
   logic [31:0]      trig_num_q, trig_num_d;
   logic             done_q, done_d;
   logic             late_q, late_d;
   logic             ovf_q, ovf_d;
   logic             ready_q, ready_d;
`ifdef ISA_TX_SEQ_STATS_EN
   logic [15:0]      late_cnt_q, late_cnt_d;
   logic [15:0]      drop_cnt_q, drop_cnt_d;
`endif

   logic [63:0]      head;
   logic             full;
   logic             empty;
   logic [AW:0]      free_next;
   logic             pop;
   word_class_e      head_class;
   logic [TS_W-1:0]  head_ts;
   logic             start_run;
   logic             fire;
   logic [TS_W-1:0]  fire_ts;
   logic [31:0]      cnt_next;
   logic             drop;

   isa_tx_seq_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (I_clk),
      .rst       (I_rst),
      .wr_en     (I_tx_en),
      .wr_data   (I_tx_data),
      .rd_en     (pop),
      .rd_data   (head),
      .full      (full),
      .empty     (empty),
      .free_next (free_next)
   );

   assign head_class = classify_word(head, TRIG_ADDR);
   assign head_ts    = head[TS_W-1:0];
   assign pop        = !empty && ((state_q == ST_IDLE) || (state_q == ST_RUN));

   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      target_d   = target_q;
      run_d      = run_q;
      play_d     = 1'b0;
      play_ts_d  = play_ts_q;
      play_cnt_d = play_cnt_q;
      trig_num_d = trig_num_q;
      done_d     = 1'b0;
      late_d     = 1'b0;
      ovf_d      = ovf_q || (I_tx_en && full && !pop);
      ready_d    = 32'(free_next) > READY_MARGIN;
      start_run  = 1'b0;
      fire       = 1'b0;
      fire_ts    = target_q;
      drop       = 1'b0;

      if ((state_q == ST_RUN) || (state_q == ST_WAIT)) begin
         timer_d = timer_q + TS_W'(1);
      end

      unique case (state_q)
         ST_IDLE: begin
            if (pop) begin
               if (head_class == WC_TRIG) start_run = 1'b1;
               else                       drop      = 1'b1;
            end
         end
         ST_RUN: begin
            if (pop) begin
               unique case (head_class)
                  WC_TRIG: start_run = 1'b1;
                  WC_ZERO: timer_d   = '0;
                  default: begin
                     // A target at or behind the timer fires straight from the pop cycle
                     // instead of parking in WAIT, so a stale timestamp cannot hang the run.
                     if (head_ts <= timer_q) begin
                        fire    = 1'b1;
                        fire_ts = head_ts;
                        late_d  = head_ts < timer_q;
                     end else begin
                        target_d = head_ts;
                        state_d  = ST_WAIT;
                     end
                  end
               endcase
            end
         end
         ST_WAIT: begin
            if (timer_q == target_q) begin
               fire    = 1'b1;
               fire_ts = target_q;
            end
         end
         ST_DONE: begin
            done_d  = 1'b1;
            run_d   = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      cnt_next = play_cnt_q + 32'd1;
      if (fire) begin
         play_d     = 1'b1;
         play_ts_d  = fire_ts;
         play_cnt_d = cnt_next;
         state_d    = ((trig_num_q != '0) && (cnt_next == trig_num_q)) ? ST_DONE : ST_RUN;
      end

      if (start_run) begin
         trig_num_d = head[31:0];
         timer_d    = '0;
         play_cnt_d = '0;
         run_d      = 1'b1;
         state_d    = ST_RUN;
      end
   end

`ifdef ISA_TX_SEQ_STATS_EN
   always_comb begin
      late_cnt_d = late_cnt_q;
      drop_cnt_d = drop_cnt_q;
      if (late_d && (late_cnt_q != '1)) late_cnt_d = late_cnt_q + 16'd1;
      if (drop && (drop_cnt_q != '1))   drop_cnt_d = drop_cnt_q + 16'd1;
   end

   always_ff @(posedge I_clk or posedge I_rst) begin
      if (I_rst) begin
         late_cnt_q <= '0;
         drop_cnt_q <= '0;
      end else begin
         late_cnt_q <= late_cnt_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign O_late_cnt = late_cnt_q;
   assign O_drop_cnt = drop_cnt_q;
`endif

   always_ff @(posedge I_clk or posedge I_rst) begin
      if (I_rst) begin
         state_q    <= ST_IDLE;
         timer_q    <= '0;
         target_q   <= '0;
         run_q      <= 1'b0;
         play_q     <= 1'b0;
         play_ts_q  <= '0;
         play_cnt_q <= '0;
         trig_num_q <= '0;
         done_q     <= 1'b0;
         late_q     <= 1'b0;
         ovf_q      <= 1'b0;
         ready_q    <= 1'b1;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         target_q   <= target_d;
         run_q      <= run_d;
         play_q     <= play_d;
         play_ts_q  <= play_ts_d;
         play_cnt_q <= play_cnt_d;
         trig_num_q <= trig_num_d;
         done_q     <= done_d;
         late_q     <= late_d;
         ovf_q      <= ovf_d;
         ready_q    <= ready_d;
      end
   end

   assign O_tx_ready = ready_q;
   assign O_run      = run_q;
   assign O_play     = play_q;
   assign O_play_ts  = play_ts_q;
   assign O_play_cnt = play_cnt_q;
   assign O_trig_num = trig_num_q;
   assign O_done     = done_q;
   assign O_late     = late_q;
   assign O_ovf      = ovf_q;

endmodule

// File: tb/tb_isa_tx_sequencer.sv
// Directed bench for isa_tx_sequencer: runs, rebase, late fire, overflow and mid-run reset.
module tb_isa_tx_sequencer;

   localparam logic [63:0] TRIG2 = 64'h0200_1000_0000_0002;
   localparam logic [63:0] TRIG1 = 64'h0200_1000_0000_0001;
   localparam logic [63:0] TRIG0 = 64'h0200_1000_0000_0000;

   logic        I_clk = 1'b0;
   logic        I_rst = 1'b1;
   logic [63:0] I_tx_data = '0;
   logic        I_tx_en = 1'b0;
   logic        O_tx_ready, O_run, O_play, O_done, O_late, O_ovf;
   logic [47:0] O_play_ts;
   logic [31:0] O_play_cnt, O_trig_num;
`ifdef ISA_TX_SEQ_STATS_EN
   logic [15:0] O_late_cnt, O_drop_cnt;
`endif

   isa_tx_sequencer dut (
      .I_clk      (I_clk),
      .I_rst      (I_rst),
      .I_tx_data  (I_tx_data),
      .I_tx_en    (I_tx_en),
      .O_tx_ready (O_tx_ready),
      .O_run      (O_run),
      .O_play     (O_play),
      .O_play_ts  (O_play_ts),
      .O_play_cnt (O_play_cnt),
      .O_trig_num (O_trig_num),
      .O_done     (O_done),
      .O_late     (O_late),
      .O_ovf      (O_ovf)
`ifdef ISA_TX_SEQ_STATS_EN
      ,.O_late_cnt (O_late_cnt),
      .O_drop_cnt (O_drop_cnt)
`endif
   );

   always #5 I_clk = ~I_clk;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int run_rise = 0;
   int late_events = 0;
   logic run_prev = 1'b0;
   int          play_cyc[$];
   logic [47:0] play_ts[$];
   logic [31:0] play_cnt[$];
   logic        play_late[$];
   int          done_cyc[$];

   always @(posedge I_clk) cyc <= cyc + 1;

   // Event recorder, sampled mid-cycle on the falling edge.
   always @(negedge I_clk) begin
      if (O_play) begin
         play_cyc.push_back(cyc);
         play_ts.push_back(O_play_ts);
         play_cnt.push_back(O_play_cnt);
         play_late.push_back(O_late);
      end
      if (O_done) done_cyc.push_back(cyc);
      if (O_late) late_events++;
      if (O_run && !run_prev) run_rise = cyc;
      run_prev = O_run;
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge I_clk);
         #1;
      end
   endtask

   task automatic push(input logic [63:0] w);
      I_tx_data = w;
      I_tx_en   = 1'b1;
      tick(1);
      I_tx_en   = 1'b0;
   endtask

   task automatic wait_plays(input string tag, input int n, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (play_cyc.size() >= n) break;
         tick(1);
      end
      check_val(tag, 64'(play_cyc.size()), 64'(n));
   endtask

   task automatic wait_done(input string tag, input int n, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (done_cyc.size() >= n) break;
         tick(1);
      end
      check_val(tag, 64'(done_cyc.size()), 64'(n));
   endtask

   initial begin
      tick(3);
      check_val("rst_ready", 64'(O_tx_ready), 64'd1);
      check_val("rst_run", 64'(O_run), 64'd0);
      check_val("rst_play", 64'(O_play), 64'd0);
      check_val("rst_cnt", 64'(O_play_cnt), 64'd0);
      check_val("rst_trig", 64'(O_trig_num), 64'd0);
      check_val("rst_ovf", 64'(O_ovf), 64'd0);
      I_rst = 1'b0;
      tick(2);

      // Bounded run of two plays
      push(TRIG2);
      push(64'd10);
      push(64'd20);
      wait_done("run1_done", 1, 80);
      if (play_cyc.size() >= 2 && done_cyc.size() >= 1) begin
         check_val("run1_ts0", 64'(play_ts[0]), 64'd10);
         check_val("run1_ts1", 64'(play_ts[1]), 64'd20);
         check_val("run1_cnt0", 64'(play_cnt[0]), 64'd1);
         check_val("run1_cnt1", 64'(play_cnt[1]), 64'd2);
         check_val("run1_lat0", 64'(play_cyc[0] - run_rise), 64'd11);
         check_val("run1_gap", 64'(play_cyc[1] - play_cyc[0]), 64'd10);
         check_val("run1_done_lat", 64'(done_cyc[0] - play_cyc[1]), 64'd1);
      end
      tick(1);
      check_val("run1_run_off", 64'(O_run), 64'd0);
      check_val("run1_trig", 64'(O_trig_num), 64'd2);

      // Words in IDLE are discarded
      push(64'd7);
      push(64'd0);
      tick(15);
      check_val("idle_noplay", 64'(play_cyc.size()), 64'd2);
      check_val("idle_run", 64'(O_run), 64'd0);
`ifdef ISA_TX_SEQ_STATS_EN
      check_val("idle_drop_cnt", 64'(O_drop_cnt), 64'd2);
`endif

      // Unbounded run with rebase
      push(TRIG0);
      push(64'd50);
      push(64'd0);
      push(64'd5);
      wait_plays("rb_plays", 4, 120);
      if (play_cyc.size() >= 4) begin
         check_val("rb_ts0", 64'(play_ts[2]), 64'd50);
         check_val("rb_ts1", 64'(play_ts[3]), 64'd5);
         check_val("rb_cnt1", 64'(play_cnt[3]), 64'd2);
         check_val("rb_lat0", 64'(play_cyc[2] - run_rise), 64'd51);
         check_val("rb_gap", 64'(play_cyc[3] - play_cyc[2]), 64'd7);
      end

      // Late timestamp fires at once
      tick(100);
      check_val("late_run", 64'(O_run), 64'd1);
      push(64'd30);
      wait_plays("late_plays", 5, 10);
      if (play_cyc.size() >= 5) begin
         check_val("late_ts", 64'(play_ts[4]), 64'd30);
         check_val("late_flag", 64'(play_late[4]), 64'd1);
         check_val("late_cnt", 64'(play_cnt[4]), 64'd3);
      end
      check_val("late_events", 64'(late_events), 64'd1);
`ifdef ISA_TX_SEQ_STATS_EN
      check_val("late_stat", 64'(O_late_cnt), 64'd1);
`endif

      // Fill FIFO while parked in WAIT on a far target
      push(64'h0000_1000_0000);
      tick(3);
      for (int i = 0; i < 17; i++) begin
         push(64'd100 + 64'(i));
         check_val($sformatf("ovf_ready_%0d", i), 64'(O_tx_ready),
                   64'(((i + 1 > 16) ? 0 : 16 - (i + 1)) > 2));
         if (i == 15) check_val("ovf_before", 64'(O_ovf), 64'd0);
         if (i == 16) check_val("ovf_after", 64'(O_ovf), 64'd1);
      end
      tick(5);
      check_val("ovf_sticky", 64'(O_ovf), 64'd1);
      check_val("ovf_noplay", 64'(play_cyc.size()), 64'd5);

      // Asynchronous reset while waiting
      I_rst = 1'b1;
      #1;
      check_val("arst_ready", 64'(O_tx_ready), 64'd1);
      check_val("arst_ovf", 64'(O_ovf), 64'd0);
      check_val("arst_run", 64'(O_run), 64'd0);
      check_val("arst_cnt", 64'(O_play_cnt), 64'd0);
`ifdef ISA_TX_SEQ_STATS_EN
      check_val("arst_late_stat", 64'(O_late_cnt), 64'd0);
`endif
      tick(2);
      I_rst = 1'b0;
      tick(8);
      check_val("arst_empty", 64'(play_cyc.size()), 64'd5);
      push(TRIG1);
      push(64'd3);
      wait_done("clean_done", 2, 40);
      if (play_cyc.size() >= 6) begin
         check_val("clean_ts", 64'(play_ts[5]), 64'd3);
         check_val("clean_cnt", 64'(play_cnt[5]), 64'd1);
         check_val("clean_lat", 64'(play_cyc[5] - run_rise), 64'd4);
      end
      check_val("clean_plays", 64'(play_cyc.size()), 64'd6);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/isa_tx_sequencer.md
Name: isa_tx_sequencer

Overview:
- Downstream consumer of the ISA decode stage's tx stream: each word arrives as a 64-bit data word with a one-cycle enable.
- Buffers words in a small synchronous FIFO and drives a ready level back toward the decode/capture path.
- Replays the words on a free-running timebase:
  - trigger words arm a run;
  - zero words rebase time;
  - all other words are absolute timestamps at which a play strobe fires.
- Sits in the same clock domain as the decode output (read side).

Parameters:
- DEPTH, 16: FIFO entries, power of two, 4..256.
- TS_W, 48: timestamp/timer width; lower TS_W bits of a timestamp word are used.
- READY_MARGIN, 2: O_tx_ready deasserts when free entries <= READY_MARGIN; absorbs producer pipeline slack.
- TRIG_ADDR, 32'h0200_1000: upper-word value identifying a trigger word.

Ports:
- I_clk  in  1  single clock for the whole block
- I_rst  in  1  asynchronous, active-high reset
- I_tx_data  in  64  word from decode stage
- I_tx_en  in  1  one-cycle write strobe; no handshake, the word is taken whenever asserted
- O_tx_ready  out  1  level: room available (see READY_MARGIN)
- O_run  out  1  high while a run is active
- O_play  out  1  one-cycle strobe at timestamp match
- O_play_ts  out  TS_W  timestamp of the current play, valid with O_play
- O_play_cnt  out  32  plays in current run, cleared on trigger
- O_trig_num  out  32  latched run length (lower 32 bits of the trigger word)
- O_done  out  1  one-cycle strobe at run completion
- O_late  out  1  one-cycle strobe: timestamp already passed when popped
- O_ovf  out  1  sticky: write attempted while full

Behaviour:
- Reset: all outputs 0 except O_tx_ready=1; FIFO empty; timer 0; state IDLE. Reset mid-run discards all FIFO contents and in-flight state.
- Write: I_tx_en with FIFO not full stores the word; it is poppable on the next cycle.
  - Write when full: word dropped, O_ovf set (sticky until reset).
  - Simultaneous push and pop when full: the push is accepted.
- O_tx_ready = registered (free entries after this cycle > READY_MARGIN).
- Word classes, by the head entry:
  - TRIG: [63:32]==TRIG_ADDR.
  - ZERO: all 64 bits 0.
  - TS: anything else.
- FSM states: IDLE, RUN, WAIT, DONE.
- IDLE:
  - Pop one word per cycle when not empty.
  - TRIG: latch O_trig_num=[31:0], clear timer and O_play_cnt, set O_run, go to RUN.
  - ZERO/TS in IDLE: discarded.
- RUN:
  - Timer increments each cycle; wraps at 2^TS_W without flagging.
  - Pop when not empty.
  - ZERO: timer <= 0 next cycle.
  - TRIG: restarts the run as in IDLE.
  - TS: load target T=[TS_W-1:0] and go to WAIT. If T < timer at the pop cycle, assert O_late and fire immediately; the next cycle is a play cycle.
- WAIT:
  - When timer == T: in the next cycle O_play=1, O_play_ts=T, O_play_cnt+1; return to RUN.
  - No pop occurs in WAIT.
  - When O_play_cnt reaches a nonzero O_trig_num on that play, go to DONE instead.
- DONE (one cycle):
  - O_done=1, O_run=0, timer held.
  - Go to IDLE.
  - O_trig_num==0 means unbounded: the run never ends until the next TRIG.
- Pop latency: head word is acted on in the cycle it is popped. Throughput: at most one word per cycle.

Optional Feature:
- Macro: ISA_TX_SEQ_STATS_EN.
- When defined, adds outputs O_late_cnt[15:0] and O_drop_cnt[15:0]:
  - saturating counters of O_late events and of words discarded in IDLE;
  - cleared by reset only.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package isa_tx_seq_pkg holds:
  - state enum (IDLE, RUN, WAIT, DONE);
  - word-class enum (TRIG, ZERO, TS);
  - TRIG_ADDR default.
- Sub-module isa_tx_seq_fifo: synchronous DEPTH x 64 FIFO with full/empty/free-count outputs.
- Classification and FSM live in the top.

Test Plan:
- Reset then push TRIG 0x0200_1000_0000_0002, TS 10, TS 20 -> O_run=1; O_play at timer 10 and 20 with O_play_cnt 1, 2; O_done one cycle after the second play; O_run=0.
- In RUN, push TS 50, ZERO, TS 5 -> play at timer 50; timer rebased to 0; next play 5 cycles after the rebase.
- In RUN at timer ~100, push TS 30 -> O_late pulse, immediate O_play with O_play_ts=30, no hang.
- In IDLE, push TS 7 and ZERO -> both discarded, no O_play; with ISA_TX_SEQ_STATS_EN, O_drop_cnt=2.
- Push DEPTH+1 words while in WAIT -> O_tx_ready low once free <= 2; 17th word dropped; O_ovf=1 and stays set.
- Assert I_rst during WAIT -> all outputs at reset values immediately; FIFO empty; a new TRIG starts a clean run.
